// File: rtl/hamming_rr_ctrl_if.sv
// Codeword source, handshake and result bus for hamming_rr_ctrl.
// The design uses the slave modport. Producers and the consumer use the master modport.
interface hamming_rr_ctrl_if;
   logic       a_valid;
   logic       a_ready;
   logic [6:0] a_cw;
   logic       b_valid;
   logic       b_ready;
   logic [6:0] b_cw;
   logic       out_valid;
   logic       out_ready;
   logic       out_src;
   logic [6:0] out_cw;
   logic [3:0] out_data;
   logic [2:0] out_syndrome;
   logic       out_corrected;

   modport master (
      output a_valid, a_cw, b_valid, b_cw, out_ready,
      input  a_ready, b_ready, out_valid, out_src, out_cw, out_data,
             out_syndrome, out_corrected
   );

   modport slave (
      input  a_valid, a_cw, b_valid, b_cw, out_ready,
      output a_ready, b_ready, out_valid, out_src, out_cw, out_data,
             out_syndrome, out_corrected
   );
endinterface

// File: rtl/hamming_rr_ctrl.sv
// Round-robin sharing of one Hamming(7,4) single-error corrector between two sources.
// Stage S1 captures the granted codeword and its syndrome. The OUT stage presents the corrected result.
module hamming_rr_ctrl #(
   parameter int unsigned CNT_W      = 8,
   parameter bit          FIRST_PRIO = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   hamming_rr_ctrl_if.slave   bus,
   input  logic               clr_cnt,
   output logic [CNT_W-1:0]   err_cnt_a,
   output logic [CNT_W-1:0]   err_cnt_b
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // The syndrome is {s4,s2,s1}, where cw[i] is Hamming position i+1.
   function automatic logic [2:0] calc_syndrome(input logic [6:0] cw);
      calc_syndrome = {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
                       cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
                       cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
   endfunction

   logic             s1_valid_q, s1_valid_d;
   logic             s1_src_q, s1_src_d;
   logic [6:0]       s1_cw_q, s1_cw_d;
   logic [2:0]       s1_syn_q, s1_syn_d;
   logic             prio_q, prio_d;
   logic             out_valid_q, out_valid_d;
   logic             out_src_q, out_src_d;
   logic [6:0]       out_cw_q, out_cw_d;
   logic [3:0]       out_data_q, out_data_d;
   logic [2:0]       out_syn_q, out_syn_d;
   logic             out_corr_q, out_corr_d;
   logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

   logic       adv2;
   logic       s1_load_ok;
   logic       grant_b;
   logic       a_acc;
   logic       b_acc;
   logic       out_hs;
   logic [7:0] flip_onehot;
   logic [6:0] fixed_cw;

   always_comb begin
      // NOTE: every signal gets a value at the top of the block, so no path can infer a latch.
      adv2        = !out_valid_q || bus.out_ready;
      s1_load_ok  = !s1_valid_q || adv2;
      grant_b     = (bus.a_valid && bus.b_valid) ? prio_q : bus.b_valid;
      a_acc       = !rst && s1_load_ok && bus.a_valid && !grant_b;
      b_acc       = !rst && s1_load_ok && bus.b_valid && grant_b;
      out_hs      = out_valid_q && bus.out_ready;

      // A syndrome of zero shifts the one-hot bit into bit 0. That bit is dropped, so the mask is empty.
      flip_onehot = 8'b1 << s1_syn_q;
      fixed_cw    = s1_cw_q ^ flip_onehot[7:1];

      s1_valid_d  = s1_valid_q;
      s1_src_d    = s1_src_q;
      s1_cw_d     = s1_cw_q;
      s1_syn_d    = s1_syn_q;
      prio_d      = prio_q;
      out_valid_d = out_valid_q;
      out_src_d   = out_src_q;
      out_cw_d    = out_cw_q;
      out_data_d  = out_data_q;
      out_syn_d   = out_syn_q;
      out_corr_d  = out_corr_q;
      cnt_a_d     = cnt_a_q;
      cnt_b_d     = cnt_b_q;

      if (adv2) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_src_d  = s1_src_q;
            out_cw_d   = fixed_cw;
            out_data_d = {fixed_cw[6], fixed_cw[5], fixed_cw[4], fixed_cw[2]};
            out_syn_d  = s1_syn_q;
            out_corr_d = |s1_syn_q;
         end
         s1_valid_d = 1'b0;
      end

      if (a_acc || b_acc) begin
         s1_valid_d = 1'b1;
         s1_src_d   = b_acc;
         s1_cw_d    = b_acc ? bus.b_cw : bus.a_cw;
         s1_syn_d   = calc_syndrome(b_acc ? bus.b_cw : bus.a_cw);
         prio_d     = !b_acc;
      end

      if (out_hs && out_corr_q) begin
         if (!out_src_q && cnt_a_q != CNT_MAX) cnt_a_d = cnt_a_q + CNT_ONE;
         if (out_src_q && cnt_b_q != CNT_MAX)  cnt_b_d = cnt_b_q + CNT_ONE;
      end
      if (clr_cnt) begin
         cnt_a_d = '0;
         cnt_b_d = '0;
      end
   end

   // NOTE: state updates use non-blocking assignments, so every flop samples values from before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_src_q    <= 1'b0;
         s1_cw_q     <= '0;
         s1_syn_q    <= '0;
         prio_q      <= FIRST_PRIO;
         out_valid_q <= 1'b0;
         out_src_q   <= 1'b0;
         out_cw_q    <= '0;
         out_data_q  <= '0;
         out_syn_q   <= '0;
         out_corr_q  <= 1'b0;
         cnt_a_q     <= '0;
         cnt_b_q     <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_src_q    <= s1_src_d;
         s1_cw_q     <= s1_cw_d;
         s1_syn_q    <= s1_syn_d;
         prio_q      <= prio_d;
         out_valid_q <= out_valid_d;
         out_src_q   <= out_src_d;
         out_cw_q    <= out_cw_d;
         out_data_q  <= out_data_d;
         out_syn_q   <= out_syn_d;
         out_corr_q  <= out_corr_d;
         cnt_a_q     <= cnt_a_d;
         cnt_b_q     <= cnt_b_d;
      end
   end

   assign bus.a_ready       = a_acc;
   assign bus.b_ready       = b_acc;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_src       = out_src_q;
   assign bus.out_cw        = out_cw_q;
   assign bus.out_data      = out_data_q;
   assign bus.out_syndrome  = out_syn_q;
   assign bus.out_corrected = out_corr_q;
   assign err_cnt_a         = cnt_a_q;
   assign err_cnt_b         = cnt_b_q;

endmodule

// File: tb/tb_hamming_rr_ctrl.sv
// Self-checking bench for hamming_rr_ctrl: directed scenarios, then randomized traffic.
// A queue-based reference model of the in-flight words checks the traffic every cycle.
module tb_hamming_rr_ctrl;
   localparam int CNT_W      = 2;
   localparam bit FIRST_PRIO = 1'b0;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   typedef struct {
      logic       src;
      logic [6:0] cw;
      int         age;
   } item_t;

   logic             clk     = 1'b0;
   logic             rst     = 1'b0;
   logic             clr_cnt = 1'b0;
   logic [CNT_W-1:0] err_cnt_a;
   logic [CNT_W-1:0] err_cnt_b;

   hamming_rr_ctrl_if bus();

   hamming_rr_ctrl #(.CNT_W(CNT_W), .FIRST_PRIO(FIRST_PRIO)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .clr_cnt   (clr_cnt),
      .err_cnt_a (err_cnt_a),
      .err_cnt_b (err_cnt_b)
   );

   always #5 clk = ~clk;

   item_t q[$];
   logic  m_prio;
   int    m_cnt[2];
   int    tests_run    = 0;
   int    tests_failed = 0;
   logic  hs_a = 1'b0;
   logic  hs_b = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // The syndrome is the XOR of the positions of all set bits. The model then flips the bit at that position.
   function automatic logic [6:0] ref_fix(input logic [6:0] cw, output logic [2:0] syn);
      logic [6:0] res;
      syn = 3'd0;
      for (int i = 0; i < 7; i++) if (cw[i]) syn ^= 3'(i + 1);
      res = cw;
      if (syn != 3'd0) res[int'(syn) - 1] = ~cw[int'(syn) - 1];
      return res;
   endfunction

   task automatic model_reset();
      q.delete();
      m_prio   = FIRST_PRIO;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
   endtask

   // One clock: compare at the negedge, then update the model at the posedge, then return 1 time unit later.
   task automatic cycle();
      logic       av, bv, ordy, clr, lo, gb, ea, eb, ev;
      logic [6:0] acw, bcw, fx;
      logic [2:0] syn;
      syn = 3'd0;
      @(negedge clk);
      av = bus.a_valid; bv = bus.b_valid; acw = bus.a_cw; bcw = bus.b_cw;
      ordy = bus.out_ready; clr = clr_cnt;
      lo = (q.size() < 2) || ordy;
      gb = (av && bv) ? m_prio : bv;
      ea = lo && av && !gb;
      eb = lo && bv && gb;
      ev = (q.size() > 0) && (q[0].age > 0);
      check("a_ready", bus.a_ready, ea);
      check("b_ready", bus.b_ready, eb);
      check("out_valid", bus.out_valid, ev);
      check("err_cnt_a", err_cnt_a, m_cnt[0]);
      check("err_cnt_b", err_cnt_b, m_cnt[1]);
      if (ev) begin
         fx = ref_fix(q[0].cw, syn);
         check("out_src", bus.out_src, q[0].src);
         check("out_cw", bus.out_cw, fx);
         check("out_data", bus.out_data, {fx[6], fx[5], fx[4], fx[2]});
         check("out_syndrome", bus.out_syndrome, syn);
         check("out_corrected", bus.out_corrected, syn != 3'd0);
      end
      hs_a = av && bus.a_ready;
      hs_b = bv && bus.b_ready;
      @(posedge clk);
      if (!rst) begin
         if (ev && ordy) begin
            if (syn != 3'd0 && m_cnt[q[0].src] < CNT_MAX) m_cnt[q[0].src]++;
            void'(q.pop_front());
         end
         if (clr) begin
            m_cnt[0] = 0;
            m_cnt[1] = 0;
         end
         foreach (q[i]) q[i].age++;
         if (ea || eb) begin
            q.push_back('{src: eb, cw: (eb ? bcw : acw), age: 0});
            m_prio = !eb;
         end
      end
      #1;
   endtask

   initial begin
      logic [6:0] err_cw [3];
      logic [2:0] err_sn [3];
      logic [6:0] bp_cw  [4];
      logic       exp_src;
      int         acc;
      int         n;
      err_cw = '{7'b1010100, 7'b1000101, 7'b0010101};
      err_sn = '{3'd1, 3'd5, 3'd7};
      bp_cw  = '{7'b1010101, 7'b0110011, 7'b1111111, 7'b0000000};

      // Reset: the ready outputs must stay low even with both sources valid.
      bus.a_valid = 1'b1; bus.b_valid = 1'b1;
      bus.a_cw = 7'b1010101; bus.b_cw = 7'b0110011; bus.out_ready = 1'b1;
      #1 rst = 1'b1;
      #2;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_a_ready", bus.a_ready, 0);
      check("rst_b_ready", bus.b_ready, 0);
      check("rst_out_cw", bus.out_cw, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_cnt_a", err_cnt_a, 0);
      check("rst_cnt_b", err_cnt_b, 0);
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0; bus.a_valid = 1'b0; bus.b_valid = 1'b0;

      // Clean word from A
      bus.a_valid = 1'b1; bus.a_cw = 7'b1010101;
      cycle();
      check("t1_hs", hs_a, 1);
      bus.a_valid = 1'b0;
      cycle();
      check("t1_valid", bus.out_valid, 1);
      check("t1_src", bus.out_src, 0);
      check("t1_syn", bus.out_syndrome, 0);
      check("t1_corr", bus.out_corrected, 0);
      check("t1_data", bus.out_data, 4'b1011);
      check("t1_cw", bus.out_cw, 7'b1010101);
      cycle();
      check("t1_cnt_a", err_cnt_a, 0);

      // Single-bit errors from A
      for (int k = 0; k < 3; k++) begin
         bus.a_valid = 1'b1; bus.a_cw = err_cw[k];
         cycle();
         bus.a_valid = 1'b0;
         cycle();
         check("t2_valid", bus.out_valid, 1);
         check("t2_syn", bus.out_syndrome, err_sn[k]);
         check("t2_cw", bus.out_cw, 7'b1010101);
         check("t2_data", bus.out_data, 4'b1011);
         check("t2_corr", bus.out_corrected, 1);
      end
      cycle();
      check("t2_cnt_a", err_cnt_a, 3);

      // Backpressure: A streams while the consumer stalls
      acc = 0; n = 0;
      bus.out_ready = 1'b0; bus.a_valid = 1'b1; bus.a_cw = bp_cw[0];
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (hs_a) begin
            acc++; n++;
            bus.a_cw = bp_cw[n % 4];
         end
         if (i >= 1) begin
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_out_cw", bus.out_cw, 7'b1010101);
         end
      end
      check("bp_accepted", acc, 2);
      check("bp_a_ready", bus.a_ready, 0);
      bus.a_valid = 1'b0; bus.out_ready = 1'b1;
      repeat (3) cycle();

      // Counter saturation on B, then a clear in the same cycle as a corrected handshake
      acc = 0;
      bus.b_valid = 1'b1; bus.b_cw = 7'b1010100;
      for (int i = 0; i < 20 && acc < 5; i++) begin
         cycle();
         if (hs_b) acc++;
      end
      check("sat_words", acc, 5);
      bus.b_valid = 1'b0;
      repeat (3) cycle();
      check("sat_cnt_b", err_cnt_b, 3);
      bus.b_valid = 1'b1;
      cycle();
      bus.b_valid = 1'b0;
      cycle();
      check("clr_pre_valid", bus.out_valid, 1);
      check("clr_pre_corr", bus.out_corrected, 1);
      clr_cnt = 1'b1;
      cycle();
      clr_cnt = 1'b0;
      check("clr_cnt_b", err_cnt_b, 0);
      check("clr_cnt_a", err_cnt_a, 0);

      // Fill both stages, then reset mid-stream
      bus.a_cw = 7'b1010100; bus.b_cw = 7'b0010101;
      bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.out_ready = 1'b1;
      repeat (4) cycle();
      bus.out_ready = 1'b0;
      repeat (3) cycle();
      check("full_out_valid", bus.out_valid, 1);
      check("full_a_ready", bus.a_ready, 0);
      check("full_b_ready", bus.b_ready, 0);
      check("full_cnt_a", err_cnt_a, 1);
      check("full_cnt_b", err_cnt_b, 1);
      #3 rst = 1'b1;
      #1;
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_a_ready", bus.a_ready, 0);
      check("mid_rst_b_ready", bus.b_ready, 0);
      check("mid_rst_cnt_a", err_cnt_a, 0);
      check("mid_rst_cnt_b", err_cnt_b, 0);
      check("mid_rst_out_cw", bus.out_cw, 0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0; bus.out_ready = 1'b1;

      // After reset the first grant goes to A; both sources then alternate
      cycle();
      check("first_grant_a", hs_a, 1);
      check("first_grant_b", hs_b, 0);
      exp_src = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         check("rr_one_hs", 32'(hs_a) + 32'(hs_b), 1);
         check("rr_out_valid", bus.out_valid, 1);
         check("rr_out_src", bus.out_src, exp_src);
         exp_src = !exp_src;
      end

      // Randomized traffic: while valid is high and not yet accepted, a source holds its codeword
      for (int i = 0; i < 800; i++) begin
         if (bus.a_valid && !hs_a) begin
            if ($urandom_range(0, 3) == 0) bus.a_valid = 1'b0;
         end else begin
            bus.a_valid = 1'($urandom_range(0, 1));
            bus.a_cw    = 7'($urandom);
         end
         if (bus.b_valid && !hs_b) begin
            if ($urandom_range(0, 3) == 0) bus.b_valid = 1'b0;
         end else begin
            bus.b_valid = 1'($urandom_range(0, 1));
            bus.b_cw    = 7'($urandom);
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         clr_cnt       = ($urandom_range(0, 30) == 0);
         cycle();
      end
      bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.out_ready = 1'b1; clr_cnt = 1'b0;
      repeat (4) cycle();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/hamming_rr_ctrl.md
Name: hamming_rr_ctrl

Overview:
- Shares one Hamming(7,4) single-error corrector between two codeword sources, A and B, using a round-robin arbiter.
- Sits between the raw-codeword producers and the LED/display consumer.
- Two-stage valid/ready pipeline: arbitrate and capture, then correct and present.
- Keeps a saturating corrected-error counter for each source.

Parameters:
CNT_W, 8, width of each per-source error counter
FIRST_PRIO, 0, source favoured after reset (0=A, 1=B)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
a_valid  in  1  source A codeword valid
a_ready  out  1  source A handshake accepted
a_cw  in  7  source A raw codeword
b_valid  in  1  source B codeword valid
b_ready  out  1  source B handshake accepted
b_cw  in  7  source B raw codeword
out_valid  out  1  result valid
out_ready  in  1  consumer ready
out_src  out  1  origin of result (0=A, 1=B)
out_cw  out  7  corrected codeword
out_data  out  4  decoded data {d4,d3,d2,d1}
out_syndrome  out  3  syndrome {s4,s2,s1}; 0 = no error
out_corrected  out  1  syndrome nonzero
err_cnt_a  out  CNT_W  corrected-word count, source A
err_cnt_b  out  CNT_W  corrected-word count, source B
clr_cnt  in  1  synchronous clear of both counters

Behaviour:
- Codeword mapping: cw[i] = Hamming position i+1.
  - s1 = cw0^cw2^cw4^cw6
  - s2 = cw1^cw2^cw5^cw6
  - s4 = cw3^cw4^cw5^cw6
  - Nonzero syndrome S: flip cw[S-1].
  - out_data = {cw6,cw5,cw4,cw2}, taken after correction.
- Double errors are not detected. They are miscorrected as a single error; this is accepted.
- Reset (async, any time): all outputs and registers go to 0, stage valids clear, prio = FIRST_PRIO. Any in-flight words are dropped.
- Stage 1 (S1) holds cw, src and the registered syndrome. Stage 2 (OUT) holds the registered corrected result.
- Advance rules:
  - adv2 = !out_valid | out_ready
  - S1 may load when !s1_valid | adv2
- Arbitration:
  - Only one source is ready in a given cycle.
  - Both valid: grant goes to prio.
  - One valid: grant goes to that source.
  - x_ready = grant_x & (S1 may load). Ready depends combinationally on the valid inputs and on out_ready.
- prio toggles to the non-served source only on an accepted handshake. With no handshake, prio holds.
- Latency: handshake at edge N -> out_valid at edge N+1 with no stall, N+2... under backpressure.
- Throughput: 1 word per cycle when out_ready is held high.
- out_* must remain stable while out_valid & !out_ready.
- Counters:
  - On an out_valid & out_ready handshake with out_corrected=1, the counter for out_src increments.
  - Counters saturate at 2^CNT_W-1.
  - clr_cnt wins over a same-cycle increment.
- A source dropping valid without a handshake loses nothing. Sources must hold cw while valid & !ready; the block does not check this.

Test Plan:
1. Source A only, out_ready=1, a_cw=7'b1010101 -> 1 cycle later: out_src=0, syndrome=0, out_corrected=0, out_data=4'b1011, out_cw=7'b1010101, err_cnt_a unchanged.
2. Single-bit errors through A:
   - 7'b1010100 -> syndrome=1, out_cw=7'b1010101
   - 7'b1000101 -> syndrome=5
   - 7'b0010101 -> syndrome=7
   - All three give out_data=4'b1011; err_cnt_a ends at 3.
3. A and B both valid continuously, out_ready=1, FIRST_PRIO=0 -> out_src sequence 0,1,0,1...; a_ready and b_ready are never high together; one result per cycle.
4. Backpressure: out_ready=0 for 5 cycles with A streaming -> exactly 2 words accepted, then a_ready=0; out_* stable throughout. Releasing out_ready delivers the words in order with no loss or duplication.
5. Saturation: CNT_W=2, 5 erroneous B words -> err_cnt_b=3. Pulsing clr_cnt in the same cycle as a corrected handshake -> err_cnt_b=0.
6. Reset asserted mid-stream with both stages full -> out_valid=0, ready outputs=0, and counters=0 immediately (async). After release, the first grant goes to FIRST_PRIO.
